// File: rtl/fifo_dump_ctrl.sv
// fifo_dump_ctrl: walks the ufifo dump port and streams each queued byte as "HH<SEP>", ending with CR LF.
// Define FIFO_DUMP_CTRL_HDR_EN to prefix the stream with "Q:".
module fifo_dump_ctrl #(
  parameter int          LGFLEN = 5,
  parameter logic [7:0]  SEP    = 8'h20
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_start,
  output logic              o_busy,
  output logic              o_done,
  output logic [LGFLEN-1:0] o_dmp_pos,
  input  logic [7:0]        i_dmp_data,
  input  logic              i_dmp_valid,
  output logic [7:0]        o_tx_data,
  output logic              o_tx_valid,
  input  logic              i_tx_ready
);
`ifdef FIFO_DUMP_CTRL_HDR_EN
  typedef enum logic [3:0] {S_IDLE, S_WAIT, S_FETCH, S_HI, S_LO, S_SEP, S_CR, S_LF, S_HDR0, S_HDR1} state_t;
`else
  typedef enum logic [3:0] {S_IDLE, S_WAIT, S_FETCH, S_HI, S_LO, S_SEP, S_CR, S_LF} state_t;
`endif
  state_t state, state_nx;
  logic [7:0] byte_q, byte_nx, tx_nx;
  logic       xfer, last, valid_nx;
  function automatic logic [7:0] hex(input logic [3:0] n);
    return (n < 4'd10) ? 8'h30 + {4'h0, n} : 8'h37 + {4'h0, n};
  endfunction
  assign xfer    = o_tx_valid & i_tx_ready;
  assign last    = o_dmp_pos == '1;
  assign o_busy  = state != S_IDLE;
  assign o_done  = (state == S_LF) & xfer;
  // the entry is snapshotted here so HI and LO always describe the same byte
  assign byte_nx = (state == S_FETCH) ? i_dmp_data : byte_q;
  always_comb begin
    state_nx = state;
    case (state)
`ifdef FIFO_DUMP_CTRL_HDR_EN
      S_IDLE:  state_nx = i_start ? S_HDR0 : S_IDLE;
      S_HDR0:  state_nx = xfer ? S_HDR1 : S_HDR0;
      S_HDR1:  state_nx = xfer ? S_WAIT : S_HDR1;
`else
      S_IDLE:  state_nx = i_start ? S_WAIT : S_IDLE;
`endif
      S_WAIT:  state_nx = S_FETCH;
      S_FETCH: state_nx = i_dmp_valid ? S_HI : S_CR;
      S_HI:    state_nx = xfer ? S_LO : S_HI;
      S_LO:    state_nx = xfer ? S_SEP : S_LO;
      S_SEP:   state_nx = xfer ? (last ? S_CR : S_WAIT) : S_SEP;
      S_CR:    state_nx = xfer ? S_LF : S_CR;
      S_LF:    state_nx = xfer ? S_IDLE : S_LF;
      default: state_nx = S_IDLE;
    endcase
  end
  // outputs are registered from the next state, so they line up with the state register
  always_comb begin
    tx_nx    = o_tx_data;
    valid_nx = 1'b1;
    case (state_nx)
`ifdef FIFO_DUMP_CTRL_HDR_EN
      S_HDR0:  tx_nx = 8'h51;
      S_HDR1:  tx_nx = 8'h3A;
`endif
      S_HI:    tx_nx = hex(byte_nx[7:4]);
      S_LO:    tx_nx = hex(byte_nx[3:0]);
      S_SEP:   tx_nx = SEP;
      S_CR:    tx_nx = 8'h0D;
      S_LF:    tx_nx = 8'h0A;
      default: valid_nx = 1'b0;
    endcase
  end
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state      <= S_IDLE;
      byte_q     <= 8'h00;
      o_dmp_pos  <= '0;
      o_tx_valid <= 1'b0;
      o_tx_data  <= 8'h00;
    end else begin
      state      <= state_nx;
      byte_q     <= byte_nx;
      o_tx_valid <= valid_nx;
      o_tx_data  <= tx_nx;
      if (state == S_IDLE && i_start)
        o_dmp_pos <= '0;
      else if (state == S_SEP && xfer && !last)
        o_dmp_pos <= o_dmp_pos + 1'b1;
    end
  end
endmodule

// File: tb/tb_fifo_dump_ctrl.sv
// tb_fifo_dump_ctrl: directed checks of the FIFO dump-to-hex streamer against a small bench FIFO.
module tb_fifo_dump_ctrl;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       busy, done, tx_valid;
  logic       tx_ready = 1'b1;
  logic [4:0] pos;
  logic [7:0] dmp_data, tx_data;
  logic       dmp_valid;
  logic [7:0] mem [32];
  int         cnt = 0;
  int         n_chk = 0, n_err = 0, done_cnt = 0;
  logic [7:0] rxq [$];
  int         plog [$];
  logic       busy_prev = 1'b0;
  logic [4:0] pos_prev = '0;
`ifdef FIFO_DUMP_CTRL_HDR_EN
  localparam bit    HDR = 1'b1;
  localparam string PFX = "Q:";
`else
  localparam bit    HDR = 1'b0;
  localparam string PFX = "";
`endif
  localparam string HX = "0123456789ABCDEF";
  fifo_dump_ctrl dut (
    .i_clk(clk), .i_rst(rst), .i_start(start), .o_busy(busy), .o_done(done),
    .o_dmp_pos(pos), .i_dmp_data(dmp_data), .i_dmp_valid(dmp_valid),
    .o_tx_data(tx_data), .o_tx_valid(tx_valid), .i_tx_ready(tx_ready)
  );
  always #5 clk = ~clk;
  always @(posedge clk) begin
    dmp_data  <= mem[pos];
    dmp_valid <= ({27'd0, pos} < cnt);
  end
  always @(negedge clk) begin
    if (!rst && tx_valid && tx_ready) rxq.push_back(tx_data);
    if (done) done_cnt++;
    if (busy && (!busy_prev || pos != pos_prev)) plog.push_back(int'(pos));
    busy_prev = busy;
    pos_prev  = pos;
  end
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic chk_stream(input string tag, input int rb, input string exp);
    chk({tag, " len"}, rxq.size() - rb, exp.len());
    for (int i = 0; i < exp.len(); i++)
      if (rb + i < rxq.size()) chk($sformatf("%s[%0d]", tag, i), {24'd0, rxq[rb + i]}, {24'd0, exp[i]});
  endtask
  task automatic pulse_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask
  task automatic wait_done(input string tag, input int d0);
    int k = 0;
    while (done_cnt == d0 && k < 2000) begin
      step();
      k++;
    end
    chk({tag, " done seen"}, done_cnt != d0, 1);
    step();
    step();
    chk({tag, " done once"}, done_cnt - d0, 1);
    chk({tag, " busy low"}, busy, 0);
  endtask
  task automatic load(input int n);
    for (int i = 0; i < 32; i++) mem[i] = 8'(i);
    cnt = n;
  endtask
  initial begin
    int rb, pb, d0, k;
    logic v0, v1, v2;
    string s;
    load(0);
    step();
    step();
    rst = 1'b0;
    chk("reset valid", tx_valid, 0);
    chk("reset data", tx_data, 8'h00);
    chk("reset pos", pos, 0);
    chk("reset busy", busy, 0);
    chk("reset done", done, 0);
    // empty FIFO
    rb = rxq.size(); d0 = done_cnt;
    pulse_start();
    wait_done("empty", d0);
    chk_stream("empty", rb, {PFX, "\r\n"});
    // three entries, latency and position walk
    mem[0] = 8'h00; mem[1] = 8'h01; mem[2] = 8'hAB; cnt = 3;
    rb = rxq.size(); pb = plog.size(); d0 = done_cnt;
    pulse_start();
    v0 = tx_valid;
    step(); v1 = tx_valid;
    step(); v2 = tx_valid;
    if (HDR) chk("hdr latency", v0, 1);
    else begin
      chk("lat edge0", v0, 0);
      chk("lat edge1", v1, 0);
      chk("lat edge2", v2, 1);
    end
    wait_done("three", d0);
    chk_stream("three", rb, {PFX, "00 01 AB \r\n"});
    chk("three pos count", plog.size() - pb, 4);
    for (int i = 0; i < 4; i++)
      if (pb + i < plog.size()) chk($sformatf("three pos[%0d]", i), plog[pb + i], i);
    // backpressure on 'A'
    rb = rxq.size(); d0 = done_cnt;
    pulse_start();
    k = 0;
    while (!(tx_valid && tx_data == 8'h41) && k < 200) begin
      step();
      k++;
    end
    tx_ready = 1'b0;
    chk("A reached", tx_valid && tx_data == 8'h41, 1);
    for (int i = 0; i < 5; i++) begin
      step();
      chk($sformatf("stall data %0d", i), tx_data, 8'h41);
      chk($sformatf("stall valid %0d", i), tx_valid, 1);
    end
    tx_ready = 1'b1;
    wait_done("stall", d0);
    chk_stream("stall", rb, {PFX, "00 01 AB \r\n"});
    // full FIFO
    load(32);
    s = PFX;
    for (int i = 0; i < 32; i++) s = {s, HX.substr(i / 16, i / 16), HX.substr(i % 16, i % 16), " "};
    s = {s, "\r\n"};
    rb = rxq.size(); pb = plog.size(); d0 = done_cnt;
    pulse_start();
    wait_done("full", d0);
    chk_stream("full", rb, s);
    chk("full pos count", plog.size() - pb, 32);
    if (plog.size() > 0) chk("full last pos", plog[$], 31);
    chk("full final pos", pos, 31);
    // restart ignored, then reset mid-dump
    mem[0] = 8'h00; mem[1] = 8'h01; mem[2] = 8'hAB; cnt = 3;
    rb = rxq.size(); d0 = done_cnt;
    pulse_start();
    k = 0;
    while (rxq.size() - rb < PFX.len() + 1 && k < 200) begin
      step();
      k++;
    end
    pulse_start();
    k = 0;
    while (rxq.size() - rb < PFX.len() + 4 && k < 200) begin
      step();
      k++;
    end
    rst = 1'b1;
    tx_ready = 1'b0;
    step();
    chk("rst valid", tx_valid, 0);
    chk("rst pos", pos, 0);
    chk("rst busy", busy, 0);
    rst = 1'b0;
    tx_ready = 1'b1;
    step();
    step();
    chk("rst no done", done_cnt - d0, 0);
    chk_stream("rst prefix", rb, {PFX, "00 0"});
    rb = rxq.size(); d0 = done_cnt;
    pulse_start();
    wait_done("fresh", d0);
    chk_stream("fresh", rb, {PFX, "00 01 AB \r\n"});
    // single signed -1 entry
    mem[0] = 8'hFF; cnt = 1;
    rb = rxq.size(); d0 = done_cnt;
    pulse_start();
    wait_done("ff", d0);
    chk_stream("ff", rb, {PFX, "FF \r\n"});
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
    $finish;
  end
endmodule
